// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler that time-shares one registered array multiplier among
// NUM_REQ requesters, with a valid/ready request side and a one-hot response side.

module rca_mult #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic [2*DATA_WIDTH-1:0]   product
);

    logic [2*DATA_WIDTH-1:0] partial_sum;

    always_comb begin
        // NOTE: blocking '=' here on purpose; each loop pass adds onto the sum built so far.
        partial_sum = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (b[i]) begin
                partial_sum = partial_sum + ({{DATA_WIDTH{1'b0}}, a} << i);
            end
        end
    end

    // The product register clears whenever the multiplier is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking '<=' for all state so every register samples pre-edge values.
        if (!rst_n) begin
            product <= '0;
        end else if (!enable) begin
            product <= '0;
        end else begin
            product <= partial_sum;
        end
    end

endmodule

module mult_rr_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [2*DATA_WIDTH-1:0]       rsp_result,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   op_a, op_b;
    logic [IDX_W-1:0]        owner, last_grant;
    logic [IDX_W-1:0]        grant_idx, cand;
    logic                    any_valid;
    logic                    mult_en;
    logic                    accept;

    // Scan from highest to lowest distance so the nearest requester after
    // last_grant is the one left standing.
    always_comb begin
        any_valid = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                any_valid = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign accept = (state == IDLE) && any_valid && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = MUL;
            MUL:     state_next = RESP;
            RESP:    if (rsp_ready[owner]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the block leaves it unassigned (no latches).
        req_ready = '0;
        rsp_valid = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
        if (state == RESP) begin
            rsp_valid[owner] = 1'b1;
        end
        mult_en = (state != IDLE);
        busy    = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            owner      <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (accept) begin
            op_a       <= req_a[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            op_b       <= req_b[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            owner      <= grant_idx;
            last_grant <= grant_idx;
        end
    end

    rca_mult #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (mult_en),
        .a       (op_a),
        .b       (op_b),
        .product (rsp_result)
    );

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.

module tb_mult_rr_scheduler;

    localparam int W = 32;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a, req_b;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [2*W-1:0]   rsp_result;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: one operation in flight at most, aged in cycles since handshake.
    logic             m_busy;
    int               m_age;
    int               m_owner;
    int               m_lg;
    logic [63:0]      m_prod;
    int               grant_q[$];
    int               grant_cyc[$];
    logic [63:0]      rsp_q[$];

    mult_rr_scheduler #(.DATA_WIDTH(W), .NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle model compare, sampled on the falling edge.
    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rv;
        int           win;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_lg   = N - 1;
            check("rst_req_ready", 64'(req_ready), 64'(0));
            check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_rsp_result", rsp_result, 64'(0));
        end else begin
            exp_ready = '0;
            exp_rv    = '0;
            win       = -1;
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    if (win < 0 && req_valid[(m_lg + k) % N]) win = (m_lg + k) % N;
                end
                if (win >= 0) exp_ready[win] = 1'b1;
            end
            if (m_busy && m_age >= 2) exp_rv[m_owner] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            check("busy", 64'(busy), 64'(m_busy));
            if (exp_rv != '0) check("rsp_result", rsp_result, m_prod);

            if (!m_busy && win >= 0) begin
                m_busy  = 1'b1;
                m_age   = 1;
                m_owner = win;
                m_lg    = win;
                m_prod  = 64'(req_a[win*W +: W]) * 64'(req_b[win*W +: W]);
                grant_q.push_back(win);
                grant_cyc.push_back(cyc);
            end else if (m_busy) begin
                if (m_age >= 2 && rsp_ready[m_owner]) begin
                    m_busy = 1'b0;
                    rsp_q.push_back(m_prod);
                end else begin
                    m_age++;
                end
            end
        end
    end

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic do_single(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [63:0] exp, input string nm);
        logic [N-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        @(posedge clk); #1;
        set_op(i, a, b);
        req_valid = oh;
        @(negedge clk);
        check({nm, "_ready_T"}, 64'(req_ready), 64'(oh));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check({nm, "_busy_T1"}, 64'(busy), 64'(1));
        @(negedge clk);
        check({nm, "_rsp_valid_T2"}, 64'(rsp_valid), 64'(oh));
        check({nm, "_rsp_result_T2"}, rsp_result, exp);
        @(negedge clk);
        check({nm, "_idle_T3"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int s, r;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(posedge clk);
        #1 rst_n  = 1'b1;
        rsp_ready = '1;

        // Single request from requester 1.
        do_single(1, 32'd3, 32'd5, 64'd15, "single");
        check("model_single", rsp_q[$], 64'd15);

        // Extreme operands.
        do_single(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max_sq");
        do_single(0, 32'd0, 32'hFFFF_FFFF, 64'd0, "zero_a");

        // Fairness: all four held valid from a fresh reset.
        do_reset();
        s = grant_q.size();
        r = rsp_q.size();
        @(posedge clk); #1;
        set_op(0, 32'd2, 32'd7);
        set_op(1, 32'd3, 32'd11);
        set_op(2, 32'd4, 32'd13);
        set_op(3, 32'd5, 32'd17);
        req_valid = '1;
        repeat (13) @(posedge clk);
        #1 req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        check("fair_count", 64'(grant_q.size() - s), 64'd5);
        if (grant_q.size() - s >= 5 && rsp_q.size() - r >= 5) begin
            check("fair_g0", 64'(grant_q[s]),   64'd0);
            check("fair_g1", 64'(grant_q[s+1]), 64'd1);
            check("fair_g2", 64'(grant_q[s+2]), 64'd2);
            check("fair_g3", 64'(grant_q[s+3]), 64'd3);
            check("fair_g4", 64'(grant_q[s+4]), 64'd0);
            for (int k = 1; k < 5; k++)
                check("fair_spacing", 64'(grant_cyc[s+k] - grant_cyc[s+k-1]), 64'd3);
            check("fair_p0", rsp_q[r],   64'd14);
            check("fair_p1", rsp_q[r+1], 64'd33);
            check("fair_p2", rsp_q[r+2], 64'd52);
            check("fair_p3", rsp_q[r+3], 64'd85);
            check("fair_p4", rsp_q[r+4], 64'd14);
        end

        // Back-pressure on requester 2, with requester 3 pending and rsp_ready[0] high.
        r = rsp_q.size();
        rsp_ready = 4'b0001;
        @(posedge clk); #1;
        set_op(2, 32'd6, 32'd7);
        req_valid = 4'b0100;
        @(negedge clk);
        check("bp_ready_T", 64'(req_ready), 64'b0100);
        @(posedge clk); #1;
        req_valid = 4'b1000;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", 64'(rsp_valid), 64'b0100);
            check("bp_rsp_result", rsp_result, 64'd42);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 4'b0101;
        @(negedge clk);
        check("bp_still_valid", 64'(rsp_valid), 64'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = '1;
        @(negedge clk);
        check("bp_done_busy", 64'(busy), 64'd0);
        check("bp_rsp_count", 64'(rsp_q.size() - r), 64'd1);
        if (rsp_q.size() > r) check("bp_model", rsp_q[r], 64'd42);

        // Reset while requester 1's operation is in MUL.
        r = rsp_q.size();
        @(posedge clk); #1;
        set_op(1, 32'd9, 32'd9);
        req_valid = 4'b0010;
        @(negedge clk);
        check("rm_ready_T", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_op(0, 32'd2, 32'd3);
        set_op(3, 32'd4, 32'd5);
        req_valid = 4'b1001;
        #1;
        check("rm_rsp_valid_now", 64'(rsp_valid), 64'd0);
        check("rm_busy_now", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rm_first_grant", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        req_valid = 4'b1000;
        repeat (3) @(posedge clk);
        #1 req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rm_rsp_count", 64'(rsp_q.size() - r), 64'd2);
        if (rsp_q.size() - r >= 2) begin
            check("rm_rsp0", rsp_q[r],   64'd6);
            check("rm_rsp1", rsp_q[r+1], 64'd20);
        end

        // Withdrawal: requester 2 appears during RESP for 1 and drops before IDLE.
        s = grant_q.size();
        rsp_ready = '0;
        @(posedge clk); #1;
        set_op(1, 32'd7, 32'd8);
        req_valid = 4'b0010;
        @(negedge clk);
        check("wd_ready_T", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        req_valid = 4'b0100;
        @(negedge clk);
        check("wd_no_ready_resp", 64'(req_ready), 64'd0);
        check("wd_rsp_result", rsp_result, 64'd56);
        @(posedge clk); #1;
        req_valid = 4'b1001;
        rsp_ready = 4'b0010;
        @(negedge clk);
        check("wd_resp_cycle_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("wd_next_grant", 64'(req_ready), 64'b1000);
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = '1;
        repeat (4) @(posedge clk);
        #1;
        check("wd_grant_count", 64'(grant_q.size() - s), 64'd2);
        if (grant_q.size() - s >= 2) begin
            check("wd_g0", 64'(grant_q[s]),   64'd1);
            check("wd_g1", 64'(grant_q[s+1]), 64'd3);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult_rr_scheduler.md
# mult_rr_scheduler

Round-robin scheduler that shares one `rca_mult` instance among `NUM_REQ` independent requesters. Each requester issues operand pairs over a valid/ready handshake and gets its product back on a one-hot response channel with back-pressure. The block sits between the requesting units and the multiplier and is the only driver of the multiplier's `enable` and operand inputs.

## Interface
- `DATA_WIDTH`, 32, operand width; passed through to `rca_mult`.
- `NUM_REQ`, 4, number of requesters, 2..16.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active low.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_ready`  out  NUM_REQ  per-requester accept, at most one bit high.
- `req_a`  in  NUM_REQ*DATA_WIDTH  operand A; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_b`  in  NUM_REQ*DATA_WIDTH  operand B; same slicing as `req_a`.
- `rsp_valid`  out  NUM_REQ  one-hot result valid, addressed to the owning requester.
- `rsp_ready`  in  NUM_REQ  per-requester result accept.
- `rsp_result`  out  2*DATA_WIDTH  unsigned product, shared by all requesters.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- One internal `rca_mult` instance. Its operands come from registers `op_a`/`op_b`. Its `enable` is high in MUL and RESP and low in IDLE.
- State machine, reset state IDLE:
  - IDLE: run arbitration. If any `req_valid` is high, assert `req_ready[g]` for winner g only. The handshake completes in the same cycle. On that edge: latch `op_a`/`op_b` from slice g, store owner g, update `last_grant` to g, go to MUL. With no valid request, stay in IDLE.
  - MUL: the multiplier registers the product at the end of this cycle. Go to RESP unconditionally.
  - RESP: `rsp_valid[owner]`=1 and `rsp_result` = multiplier output. Operands and `enable` stay held, so the result is stable. On `rsp_ready[owner]`=1, go to IDLE. Otherwise stay in RESP.
- Arbitration: round robin starting at `last_grant+1` modulo NUM_REQ, taking the first valid requester. `last_grant` resets to NUM_REQ-1, so requester 0 has top priority after reset.
- `req_ready` is combinational from `req_valid`, state and `last_grant`. It is 0 in MUL and RESP.
- A requester may drop `req_valid` before its handshake without penalty. Nothing is consumed until `req_ready` and `req_valid` are both high.
- `rsp_ready` bits of non-owners are ignored.
- Product is unsigned and full width: 2*DATA_WIDTH bits, no truncation or overflow.
- Reset (`rst_n`=0), at any time including mid-MUL or mid-RESP:
  - state goes to IDLE
  - `op_a`, `op_b` and owner go to 0
  - `last_grant` goes to NUM_REQ-1
  - any in-flight operation is dropped with no response.
- Reset values: `req_ready`=0, `rsp_valid`=0, `busy`=0, `rsp_result`=0. The multiplier output register clears while `enable` is low.

## Timing
- Cycle T: handshake in IDLE. T+1: MUL. T+2: `rsp_valid` high, earliest.
- Latency: 2 cycles from handshake to response.
- With `rsp_ready` tied high, one operation completes every 3 cycles. The next handshake can occur at T+3.
- Back-pressure: each cycle of `rsp_ready`=0 in RESP adds one cycle. `rsp_result` must not change while `rsp_valid` is high.
- A response handshake and a new request acceptance never share a cycle. RESP always returns to IDLE first.
- `busy` is registered: high from T+1 through the response handshake cycle.

## Test plan
- Single request, requester 1, A=3, B=5, `rsp_ready`=1:
  - `req_ready[1]` high in cycle T.
  - `rsp_valid`=4'b0010 with `rsp_result`=15 in T+2.
  - IDLE at T+3.
- Extreme operands, DATA_WIDTH=32: A=B=0xFFFFFFFF gives 0xFFFFFFFE00000001. A=0, B=0xFFFFFFFF gives 0.
- Fairness: all four `req_valid` held high with distinct operands.
  - Grant order is 0,1,2,3,0.
  - Each product matches its owner's operands.
  - Handshakes occur every 3 cycles.
- Back-pressure: hold `rsp_ready[2]` low for 5 cycles in RESP.
  - `rsp_valid[2]` and `rsp_result` stay constant.
  - `req_ready` stays 0.
  - The response completes on the first high `rsp_ready[2]`.
  - Asserting `rsp_ready[0]` meanwhile has no effect.
- Reset mid-operation: assert `rst_n`=0 during MUL.
  - Immediately: `rsp_valid`=0, `busy`=0.
  - After release, pending requests 0 and 3 are granted 0 first.
  - The dropped operation produces no response.
- Request withdrawal: requester 2 raises `req_valid` while the block is in RESP for requester 1, then drops it before IDLE.
  - No grant to 2 occurs.
  - The next grant goes to the next valid requester after 1.
